// File: rtl/chaser_pkg.sv
// Shared types and helpers for the LED chaser/fader.
// Holds the default figure-8 map, fade/direction enums and level math.
package chaser_pkg;

    localparam logic [23:0] FIGURE8_MAP = 24'hB93988;

    typedef enum logic {
        FADE_SHIFT  = 1'b0,
        FADE_LINEAR = 1'b1
    } fade_mode_e;

    typedef enum logic {
        DIR_REV = 1'b0,
        DIR_FWD = 1'b1
    } dir_e;

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == '0) ? '0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/led_chaser_fader_if.sv
// Config inputs and LED/position outputs of the chaser.
// The controller side is master, the chaser core is slave.
interface led_chaser_fader_if #(
    parameter int NUM_LEDS    = 7,
    parameter int SEQ_LEN     = 8,
    parameter int SPEED_WIDTH = 3
);
    localparam int POS_W = $clog2(SEQ_LEN);

    logic                   enable;
    logic [SPEED_WIDTH-1:0] speed;
    logic                   direction;
    logic                   bounce;
    logic                   tail_en;
    logic                   fade_linear;
    logic                   invert;
    logic [NUM_LEDS-1:0]    led_out;
    logic [POS_W-1:0]       pos;
    logic                   step_pulse;

    modport master (
        output enable, speed, direction, bounce,
        output tail_en, fade_linear, invert,
        input  led_out, pos, step_pulse
    );

    modport slave (
        input  enable, speed, direction, bounce,
        input  tail_en, fade_linear, invert,
        output led_out, pos, step_pulse
    );

endinterface

// File: rtl/led_chaser_fader_channel.sv
// One LED channel: brightness level with head/fade update
// and a registered PWM comparator driving the pin.
module led_fade_channel
    import chaser_pkg::*;
#(
    parameter int FADE_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  is_head,
    input  logic                  tail_en,
    input  logic                  fade_tick,
    input  fade_mode_e            fade_mode,
    input  logic                  invert,
    input  logic [FADE_WIDTH-1:0] pwm,
    output logic                  led
);

    logic [FADE_WIDTH-1:0] level;

    // Head relights to full; otherwise clear, decay on tick, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= '0;
        end else if (is_head) begin
            level <= '1;
        end else if (!tail_en) begin
            level <= '0;
        end else if (fade_tick) begin
            if (fade_mode == FADE_LINEAR)
                level <= FADE_WIDTH'(sat_dec(32'(level)));
            else
                level <= level >> 1;
        end
    end

    // PWM compare, registered so the pin never glitches.
    always_ff @(posedge clk) begin
        if (reset)
            led <= 1'b0;
        else
            led <= (level > pwm) ^ invert;
    end

endmodule

// File: rtl/led_chaser_fader.sv
// LED chaser with a PWM-faded tail: prescaled step, wrap or
// bounce position walk, map decode and per-LED fade channels.
module led_chaser_fader
    import chaser_pkg::*;
#(
    parameter int NUM_LEDS       = 7,
    parameter int SEQ_LEN        = 8,
    parameter int IDX_W          = 3,
    parameter logic [SEQ_LEN*IDX_W-1:0] SEQ_MAP = FIGURE8_MAP,
    parameter int FADE_WIDTH     = 4,
    parameter int PRESCALE_WIDTH = 23,
    parameter int SPEED_WIDTH    = 3,
    parameter int FADE_DIV_WIDTH = 22
) (
    input logic clk,
    input logic reset,
    led_chaser_fader_if.slave bus
);

    localparam int POS_W = $clog2(SEQ_LEN);
    localparam int PAD   = PRESCALE_WIDTH - SPEED_WIDTH;
    localparam logic [POS_W-1:0] LAST = POS_W'(SEQ_LEN - 1);

    logic [PRESCALE_WIDTH-1:0] cnt;
    logic [PRESCALE_WIDTH-1:0] thr;
    logic                      step;
    logic [POS_W-1:0]          pos;
    dir_e                      dir_q;
    logic                      step_pulse;
    logic [FADE_DIV_WIDTH-1:0] fdiv;
    logic                      fade_tick;
    logic [FADE_WIDTH-1:0]     pwm;
    logic [IDX_W-1:0]          head_idx;
    logic [NUM_LEDS-1:0]       led;

    assign thr       = {bus.speed, {PAD{1'b1}}};
    assign step      = bus.enable && (cnt >= thr);
    assign fade_tick = &fdiv;
    assign head_idx  = SEQ_MAP[int'(pos)*IDX_W +: IDX_W];

    // Step prescaler; >= so a lowered speed fires promptly.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (bus.enable)
            cnt <= step ? '0 : cnt + 1'b1;
    end

    // Position/direction walk; bounce never repeats an end.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos        <= '0;
            dir_q      <= DIR_FWD;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= step;
            if (!bus.bounce)
                dir_q <= dir_e'(bus.direction);
            if (step) begin
                if (bus.bounce) begin
                    unique case (dir_q)
                        DIR_FWD: begin
                            if (pos == LAST) begin
                                dir_q <= DIR_REV;
                                pos   <= LAST - 1'b1;
                            end else begin
                                pos <= pos + 1'b1;
                            end
                        end
                        DIR_REV: begin
                            if (pos == '0) begin
                                dir_q <= DIR_FWD;
                                pos   <= POS_W'(1);
                            end else begin
                                pos <= pos - 1'b1;
                            end
                        end
                    endcase
                end else if (bus.direction) begin
                    pos <= (pos == LAST) ? '0 : pos + 1'b1;
                end else begin
                    pos <= (pos == '0) ? LAST : pos - 1'b1;
                end
            end
        end
    end

    // Free-running fade divider and PWM counter; run while paused.
    always_ff @(posedge clk) begin
        if (reset) begin
            fdiv <= '0;
            pwm  <= '0;
        end else begin
            fdiv <= fdiv + 1'b1;
            pwm  <= pwm + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
        led_fade_channel #(
            .FADE_WIDTH (FADE_WIDTH)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .is_head   (head_idx == IDX_W'(i)),
            .tail_en   (bus.tail_en),
            .fade_tick (fade_tick),
            .fade_mode (fade_mode_e'(bus.fade_linear)),
            .invert    (bus.invert),
            .pwm       (pwm),
            .led       (led[i])
        );
    end

    assign bus.led_out    = led;
    assign bus.pos        = pos;
    assign bus.step_pulse = step_pulse;

endmodule

// File: tb/tb_led_chaser_fader.sv
// Self-checking bench for led_chaser_fader (small prescale/fade widths).
// Expected positions and levels are queued up front and popped on output.
module tb_led_chaser_fader;

    localparam int NL = 7;
    localparam int SL = 8;
    localparam int FW = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] speed;
    logic       direction;
    logic       bounce;
    logic       tail_en;
    logic       fade_linear;
    logic       invert;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned pos_q[$];
    int unsigned head_q[$];
    int unsigned fade_q[$];

    int head_tab[SL] = '{0, 1, 6, 4, 3, 2, 6, 5};

    logic [FW-1:0] lvl_a [NL];
    logic [FW-1:0] lvl_b [NL];

    led_chaser_fader_if #(.NUM_LEDS(NL), .SEQ_LEN(SL), .SPEED_WIDTH(2)) if_a ();
    led_chaser_fader_if #(.NUM_LEDS(NL), .SEQ_LEN(SL), .SPEED_WIDTH(2)) if_b ();

    assign if_a.enable      = enable;
    assign if_a.speed       = speed;
    assign if_a.direction   = direction;
    assign if_a.bounce      = bounce;
    assign if_a.tail_en     = tail_en;
    assign if_a.fade_linear = fade_linear;
    assign if_a.invert      = invert;
    assign if_b.enable      = enable;
    assign if_b.speed       = speed;
    assign if_b.direction   = direction;
    assign if_b.bounce      = bounce;
    assign if_b.tail_en     = tail_en;
    assign if_b.fade_linear = fade_linear;
    assign if_b.invert      = invert;

    led_chaser_fader #(
        .PRESCALE_WIDTH (6),
        .SPEED_WIDTH    (2),
        .FADE_DIV_WIDTH (3),
        .FADE_WIDTH     (FW)
    ) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    led_chaser_fader #(
        .SEQ_MAP        (24'hFAC688),
        .PRESCALE_WIDTH (6),
        .SPEED_WIDTH    (2),
        .FADE_DIV_WIDTH (3),
        .FADE_WIDTH     (FW)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    for (genvar g = 0; g < NL; g++) begin : g_tap
        assign lvl_a[g] = dut_a.g_chan[g].u_chan.level;
        assign lvl_b[g] = dut_b.g_chan[g].u_chan.level;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got,
                         input int unsigned exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_step(input string tag, input int limit,
                             output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_a.step_pulse && n < limit);
        if (!if_a.step_pulse)
            check({tag, " timeout"}, 32'(if_a.step_pulse), 1);
    endtask

    task automatic wait_lvl0(input int limit, output int n);
        logic [FW-1:0] prev;
        prev = lvl_a[0];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (lvl_a[0] == prev && n < limit);
        if (lvl_a[0] == prev)
            check("lvl0 timeout", n, limit + 1);
    endtask

    function automatic int count_lit_a();
        int c = 0;
        for (int i = 0; i < NL; i++)
            if (lvl_a[i] != '0) c++;
        return c;
    endfunction

    function automatic int count_lit_b();
        int c = 0;
        for (int i = 0; i < NL; i++)
            if (lvl_b[i] != '0) c++;
        return c;
    endfunction

    task automatic fade_run(input string tag);
        int n;
        wait_step({tag, " step"}, 100, n);
        check({tag, " period"}, n, 64);
        check({tag, " lvl"}, lvl_a[0], fade_q.pop_front());
        while (fade_q.size() > 0) begin
            wait_lvl0(20, n);
            check({tag, " ival"}, n, 8);
            check({tag, " lvl"}, lvl_a[0], fade_q.pop_front());
        end
        repeat (16) @(negedge clk);
        check({tag, " hold"}, lvl_a[0], 0);
    endtask

    initial begin
        int n;
        int hi;
        int pulses;

        reset       = 1'b1;
        enable      = 1'b0;
        speed       = 2'd0;
        direction   = 1'b1;
        bounce      = 1'b0;
        tail_en     = 1'b1;
        fade_linear = 1'b0;
        invert      = 1'b1;

        // reset state with invert high
        repeat (2) @(negedge clk);
        check("rst led_out", if_a.led_out, 0);
        check("rst pos", if_a.pos, 0);
        check("rst step", if_a.step_pulse, 0);
        check("rst lvl0", lvl_a[0], 0);
        invert = 1'b0;
        enable = 1'b1;
        reset  = 1'b0;

        // wrap forward, speed 0
        for (int k = 0; k < SL; k++) begin
            pos_q.push_back((k + 1) % SL);
            head_q.push_back(head_tab[(k + 1) % SL]);
        end
        for (int k = 0; k < SL; k++) begin
            int unsigned h;
            wait_step("wrap", 40, n);
            check("wrap period", n + ((k > 0) ? 1 : 0), 16);
            check("wrap pos", if_a.pos, pos_q.pop_front());
            h = head_q.pop_front();
            @(negedge clk);
            check("wrap head", lvl_a[h], 15);
        end

        // bounce, direction input ignored, speed 3
        bounce    = 1'b1;
        direction = 1'b0;
        speed     = 2'd3;
        do_reset();
        for (int k = 1; k < SL; k++) pos_q.push_back(k);
        for (int k = SL - 2; k >= 0; k--) pos_q.push_back(k);
        pos_q.push_back(1);
        while (pos_q.size() > 0) begin
            wait_step("bounce", 100, n);
            check("bounce period", n, 64);
            check("bounce pos", if_a.pos, pos_q.pop_front());
        end

        // shift fade of LED0
        bounce    = 1'b0;
        direction = 1'b1;
        do_reset();
        fade_q = '{15, 7, 3, 1, 0};
        fade_run("fade_s");

        // linear fade of LED0
        fade_linear = 1'b1;
        do_reset();
        for (int v = 15; v >= 0; v--) fade_q.push_back(v);
        fade_run("fade_l");

        // PWM duty of the head, normal and inverted
        fade_linear = 1'b0;
        speed       = 2'd0;
        do_reset();
        wait_step("pwm", 40, n);
        repeat (2) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            hi += int'(if_a.led_out[1]);
            @(negedge clk);
        end
        check("pwm full duty", hi, 15);
        wait_step("pwm inv", 40, n);
        check("pwm inv pos", if_a.pos, 3);
        invert = 1'b1;
        repeat (2) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            hi += int'(if_a.led_out[4]);
            @(negedge clk);
        end
        check("pwm inv duty", hi, 1);
        invert  = 1'b0;
        tail_en = 1'b0;
        wait_step("notail", 40, n);
        check("notail pos", if_a.pos, 5);
        repeat (2) @(negedge clk);
        check("notail lit", count_lit_a(), 1);
        check("notail head", lvl_a[2], 15);

        // pause mid-count, tail keeps decaying
        tail_en = 1'b1;
        do_reset();
        wait_step("pause", 40, n);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            pulses += int'(if_a.step_pulse);
        end
        check("pause pulses", pulses, 0);
        check("pause pos", if_a.pos, 1);
        check("pause cnt", dut_a.cnt, 5);
        check("pause lvl0", lvl_a[0], 0);
        enable = 1'b1;
        wait_step("resume", 30, n);
        check("resume wait", n, 11);
        check("resume pos", if_a.pos, 2);

        // out-of-range map entry lights nothing
        tail_en = 1'b0;
        do_reset();
        for (int k = 1; k < SL; k++) begin
            wait_step("oor", 40, n);
            if (k == 6) begin
                @(negedge clk);
                check("oor led6", lvl_b[6], 15);
            end
        end
        check("oor pos", if_b.pos, 7);
        repeat (3) @(negedge clk);
        check("oor lit", count_lit_b(), 0);
        check("oor led_out", if_b.led_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
